// File: rtl/panda_wb_stage.sv
// Writeback stage of the Panda core. Retires instructions from execute/memory
// and drives the register-file write port. Loads wait for the data-memory
// response, then the returned word is lane-selected and sign/zero-extended.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   ex_valid_i / ex_ready_o  retire handshake (ready is combinational: IDLE)
//   ex_rd_addr_i, ex_rd_we_i destination register and write enable
//   ex_rd_data_sel_i         0=ALU, 1=LSU, 2=PC_INC, 3=ALU
//   ex_alu_result_i          ALU result / load address
//   ex_pc_inc_i              pc+4 link value
//   ex_lsu_width_i           0=byte, 1=half, 2/3=word
//   ex_lsu_load_unsigned_i   zero-extend when 1
//   data_rvalid_i, data_rdata_i  data-memory read response
//   rd_data_o, rd_addr_o, rd_we_o  registered writeback port
//   load_timeout_o           pulse when a load is abandoned
//   rvalid_err_o             pulse on a response arriving while idle
module panda_wb_stage #(
    parameter int unsigned LoadTimeout = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic        ex_rd_we_i,
    input  logic [1:0]  ex_rd_data_sel_i,
    input  logic [31:0] ex_alu_result_i,
    input  logic [31:0] ex_pc_inc_i,
    input  logic [1:0]  ex_lsu_width_i,
    input  logic        ex_lsu_load_unsigned_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    output logic [31:0] rd_data_o,
    output logic [4:0]  rd_addr_o,
    output logic        rd_we_o,
    output logic        load_timeout_o,
    output logic        rvalid_err_o
);

    localparam int unsigned CntW = $clog2(LoadTimeout + 1);

    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] WAIT_LOAD = 1'b1;

    localparam logic [1:0] SEL_LSU    = 2'd1;
    localparam logic [1:0] SEL_PC_INC = 2'd2;
    localparam logic [1:0] WIDTH_BYTE = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;

    logic [0:0]      state_q, state_d;
    logic [4:0]      ld_addr_q, ld_addr_d;
    logic            ld_we_q, ld_we_d;
    logic [1:0]      ld_width_q, ld_width_d;
    logic            ld_uns_q, ld_uns_d;
    logic [1:0]      ld_lsb_q, ld_lsb_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [31:0]     rd_data_q, rd_data_d;
    logic [4:0]      rd_addr_q, rd_addr_d;
    logic            rd_we_q, rd_we_d;
    logic            timeout_q, timeout_d;
    logic            rvalid_err_q, rvalid_err_d;

    logic [7:0]      byte_lane;
    logic [15:0]     half_lane;
    logic [31:0]     load_ext;

    assign ex_ready_o     = (state_q == IDLE);
    assign rd_data_o      = rd_data_q;
    assign rd_addr_o      = rd_addr_q;
    assign rd_we_o        = rd_we_q;
    assign load_timeout_o = timeout_q;
    assign rvalid_err_o   = rvalid_err_q;

    // Lane select and extension of the returned word using the captured load fields
    always_comb begin
        byte_lane = data_rdata_i[{ld_lsb_q, 3'b000} +: 8];
        half_lane = ld_lsb_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
        load_ext  = data_rdata_i;
        case (ld_width_q)
            WIDTH_BYTE: load_ext = ld_uns_q ? {24'd0, byte_lane}
                                            : {{24{byte_lane[7]}}, byte_lane};
            WIDTH_HALF: load_ext = ld_uns_q ? {16'd0, half_lane}
                                            : {{16{half_lane[15]}}, half_lane};
            default:    load_ext = data_rdata_i;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        ld_addr_d    = ld_addr_q;
        ld_we_d      = ld_we_q;
        ld_width_d   = ld_width_q;
        ld_uns_d     = ld_uns_q;
        ld_lsb_d     = ld_lsb_q;
        cnt_d        = cnt_q;
        rd_data_d    = rd_data_q;
        rd_addr_d    = rd_addr_q;
        rd_we_d      = 1'b0;
        timeout_d    = 1'b0;
        rvalid_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                rvalid_err_d = data_rvalid_i;
                if (ex_valid_i) begin
                    if (ex_rd_data_sel_i == SEL_LSU) begin
                        ld_addr_d  = ex_rd_addr_i;
                        ld_we_d    = ex_rd_we_i;
                        ld_width_d = ex_lsu_width_i;
                        ld_uns_d   = ex_lsu_load_unsigned_i;
                        ld_lsb_d   = ex_alu_result_i[1:0];
                        cnt_d      = '0;
                        state_d    = WAIT_LOAD;
                    end else begin
                        rd_we_d   = ex_rd_we_i && (ex_rd_addr_i != 5'd0);
                        rd_addr_d = ex_rd_addr_i;
                        rd_data_d = (ex_rd_data_sel_i == SEL_PC_INC) ? ex_pc_inc_i
                                                                     : ex_alu_result_i;
                    end
                end
            end
            WAIT_LOAD: begin
                // A response on the final counted edge still completes the load
                if (data_rvalid_i) begin
                    rd_we_d   = ld_we_q && (ld_addr_q != 5'd0);
                    rd_addr_d = ld_addr_q;
                    rd_data_d = load_ext;
                    state_d   = IDLE;
                end else if (cnt_q == CntW'(LoadTimeout - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            ld_addr_q    <= '0;
            ld_we_q      <= 1'b0;
            ld_width_q   <= '0;
            ld_uns_q     <= 1'b0;
            ld_lsb_q     <= '0;
            cnt_q        <= '0;
            rd_data_q    <= '0;
            rd_addr_q    <= '0;
            rd_we_q      <= 1'b0;
            timeout_q    <= 1'b0;
            rvalid_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ld_addr_q    <= ld_addr_d;
            ld_we_q      <= ld_we_d;
            ld_width_q   <= ld_width_d;
            ld_uns_q     <= ld_uns_d;
            ld_lsb_q     <= ld_lsb_d;
            cnt_q        <= cnt_d;
            rd_data_q    <= rd_data_d;
            rd_addr_q    <= rd_addr_d;
            rd_we_q      <= rd_we_d;
            timeout_q    <= timeout_d;
            rvalid_err_q <= rvalid_err_d;
        end
    end

endmodule

// File: doc/panda_wb_stage.md
# panda_wb_stage

Writeback stage of the Panda core: the producer end of the register-file write port (`rd_data`/`rd_addr`/`rd_we`) that the decode stage consumes. It accepts retiring instructions from execute/memory over a valid/ready handshake. For loads, it waits for the data-memory response, then aligns and sign/zero-extends the returned word. Every register write is driven from flops, as one single-cycle pulse.

## Interface
- `LoadTimeout`, default 255: maximum cycles spent waiting for `data_rvalid_i` before abandoning a load (≥1).

- `clk_i`  in  1  clock; all state on rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `ex_valid_i`  in  1  retiring instruction present.
- `ex_ready_o`  out  1  stage can accept; combinational, `state==IDLE`.
- `ex_rd_addr_i`  in  5  destination register.
- `ex_rd_we_i`  in  1  instruction writes rd.
- `ex_rd_data_sel_i`  in  2  source of rd data: 0=ALU, 1=LSU, 2=PC_INC; 3 treated as ALU.
- `ex_alu_result_i`  in  32  ALU result; for loads this is the address.
- `ex_pc_inc_i`  in  32  pc+4 (jump link value).
- `ex_lsu_width_i`  in  2  0=byte, 1=half, 2=word; 3 treated as word.
- `ex_lsu_load_unsigned_i`  in  1  zero-extend when 1, sign-extend when 0.
- `data_rvalid_i`  in  1  data-memory read response valid.
- `data_rdata_i`  in  32  data-memory read word (word-aligned).
- `rd_data_o`  out  32  writeback data to register file.
- `rd_addr_o`  out  5  writeback address.
- `rd_we_o`  out  1  writeback strobe, single-cycle pulse.
- `load_timeout_o`  out  1  one-cycle pulse when a load is abandoned.
- `rvalid_err_o`  out  1  one-cycle pulse on `data_rvalid_i` while IDLE.

## Operation
- Accept happens at a rising edge with `ex_valid_i && ex_ready_o`.
- States: IDLE, WAIT_LOAD.
- **IDLE, accept, `ex_rd_data_sel_i != 1`:**
  - Next cycle: `rd_we_o = ex_rd_we_i && (ex_rd_addr_i != 0)`, `rd_addr_o = ex_rd_addr_i`.
  - `rd_data_o` = ALU result, or `ex_pc_inc_i` if sel=2.
  - Stay IDLE.
- **IDLE, accept, sel=1 (load):**
  - Capture `rd_addr`, `rd_we`, width, unsigned, and `ex_alu_result_i[1:0]` into local registers.
  - Clear the timeout counter; go to WAIT_LOAD; no write this cycle.
- **WAIT_LOAD, `data_rvalid_i` sampled high:**
  - Next cycle: write the extended data, with `rd_we_o` gated by captured we and addr≠0.
  - Return to IDLE.
- **WAIT_LOAD, no response:**
  - Counter increments each cycle.
  - When the counter reaches `LoadTimeout-1` without a response: return to IDLE, pulse `load_timeout_o`, no write.
  - A response arriving on that same edge wins: normal write, no timeout pulse.
- **Load extraction, from captured lsb and width:**
  - Byte: lane = `data_rdata_i[8*lsb +: 8]`.
  - Half: lane = lsb[1] ? `[31:16]` : `[15:0]`; lsb[0] ignored.
  - Word: whole word; lsb ignored.
  - Result = lane zero-extended if unsigned, else sign-extended to 32.
- `data_rvalid_i` while IDLE is ignored except for a `rvalid_err_o` pulse on the next cycle.
- `ex_*` inputs are ignored when not accepted; there is no internal queue.
- `rd_we_o` is never high for two consecutive cycles from one instruction.
- Timeout counter width is `$clog2(LoadTimeout+1)`.

## Timing
- Reset (async assert):
  - state=IDLE; `rd_data_o`=0, `rd_addr_o`=0, `rd_we_o`=0, `load_timeout_o`=0, `rvalid_err_o`=0.
  - `ex_ready_o`=1; captured load fields and counter = 0.
- Non-load latency: accept at edge N → `rd_*` valid in cycle N..N+1, i.e. registered output one cycle after accept.
- Back-to-back non-loads: one accept per cycle; one write per cycle.
- Load latency:
  - Accept at edge N; `ex_ready_o`=0 from after N.
  - `data_rvalid_i` sampled at edge M > N → write during the cycle after M; `ex_ready_o`=1 after M.
  - Minimum load occupancy: 2 edges (N, N+1). The next accept is at edge M+1 at the earliest.
- Reset mid-load: pending load is dropped, no write; a response arriving after reset release produces `rvalid_err_o`.
- All outputs except `ex_ready_o` come directly from flops.

## Test plan
- **ALU writeback:** accept sel=0, rd=5, alu=0x1234_5678, we=1 → next cycle `rd_we_o`=1, `rd_addr_o`=5, `rd_data_o`=0x1234_5678; following cycle `rd_we_o`=0.
- **x0 suppression and JAL link:** accept rd=0, we=1 → `rd_we_o`=0. Then sel=2, rd=1, pc_inc=0x104 → `rd_data_o`=0x104, `rd_we_o`=1.
- **Load extension:** data=0x80FF_7F01.
  - Byte signed lsb=3 → 0xFFFF_FF80.
  - Byte unsigned lsb=2 → 0x0000_00FF.
  - Half signed lsb=2 → 0xFFFF_80FF.
  - Half unsigned lsb=1 → 0x0000_7F01.
  - Word → 0x80FF_7F01.
- **Load stall:** response delayed 3 cycles → `ex_ready_o`=0 for those cycles, a new `ex_valid_i` is not accepted, and there is exactly one write after the response.
- **Timeout:** `LoadTimeout`=4, no response → `load_timeout_o` pulses once, no `rd_we_o`, `ex_ready_o` returns to 1. A later stray `data_rvalid_i` → `rvalid_err_o` pulse.
- **Reset during WAIT_LOAD:** assert `rst_ni` low mid-wait → all outputs 0 immediately, `ex_ready_o`=1, no write after release.
